// File: rtl/counter_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : counter_sequencer_if                                             |
// | Brief   : Command/status bundle between board controls and the sequencer.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface counter_sequencer_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             dir;
  logic             auto_rl;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, stop, clear, dir, auto_rl, limit,
    input  count, busy, done, wrap
  );

  modport slave (
    input  start, stop, clear, dir, auto_rl, limit,
    output count, busy, done, wrap
  );
endinterface
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : counter_sequencer                                                |
// | Brief   : Start/pause/resume/clear run controller for a prescaled up/down  |
// |           counter; COUNTER_SEQUENCER_GRAY_EN makes count Gray-coded.       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module counter_sequencer #(
  parameter int WIDTH = 3,
  parameter int DIV   = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  counter_sequencer_if.slave ctl
);
  localparam int              c_PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_PW-1:0] c_DIV_M1 = c_PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_count, w_count_nx;
  logic [c_PW-1:0]  r_presc, w_presc_nx;
  logic             r_dir, w_dir_nx;
  logic             r_auto, w_auto_nx;
  logic [WIDTH-1:0] r_limit, w_limit_nx;
  logic             r_busy, r_done, r_wrap;
  logic             w_done_nx, w_wrap_nx;
  logic             w_tick;
  logic             w_at_term;

  assign w_tick    = (r_presc == c_DIV_M1);
  assign w_at_term = (r_count == (r_dir ? '0 : r_limit));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_presc <= '0;
      r_dir   <= 1'b0;
      r_auto  <= 1'b0;
      r_limit <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_presc <= w_presc_nx;
      r_dir   <= w_dir_nx;
      r_auto  <= w_auto_nx;
      r_limit <= w_limit_nx;
      r_busy  <= (w_state_nx == S_RUN);
      r_done  <= w_done_nx;
      r_wrap  <= w_wrap_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_presc_nx = r_presc;
    w_dir_nx   = r_dir;
    w_auto_nx  = r_auto;
    w_limit_nx = r_limit;
    w_done_nx  = 1'b0;
    w_wrap_nx  = 1'b0;
    if (ctl.clear) begin
      w_state_nx = S_IDLE;
      w_count_nx = '0;
      w_presc_nx = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (ctl.start) begin
            w_state_nx = S_RUN;
            w_dir_nx   = ctl.dir;
            w_auto_nx  = ctl.auto_rl;
            w_limit_nx = ctl.limit;
            w_count_nx = ctl.dir ? ctl.limit : '0;
            w_presc_nx = '0;
          end
        end
        S_RUN: begin
          // stop freezes everything, including a tick landing in the same cycle
          if (ctl.stop) begin
            w_state_nx = S_PAUSE;
          end else if (w_tick) begin
            w_presc_nx = '0;
            if (!w_at_term) begin
              w_count_nx = r_dir ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
            end else if (r_auto) begin
              w_count_nx = r_dir ? r_limit : '0;
              w_wrap_nx  = 1'b1;
            end else begin
              w_state_nx = S_DONE;
              w_done_nx  = 1'b1;
            end
          end else begin
            w_presc_nx = r_presc + c_PW'(1);
          end
        end
        S_PAUSE: begin
          if (ctl.start) begin
            w_state_nx = S_RUN;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

`ifdef COUNTER_SEQUENCER_GRAY_EN
  assign ctl.count = r_count ^ (r_count >> 1);
`else
  assign ctl.count = r_count;
`endif
  assign ctl.busy = r_busy;
  assign ctl.done = r_done;
  assign ctl.wrap = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_counter_sequencer                                             |
// | Brief   : Scoreboard bench for counter_sequencer at DIV = 1, 2 and 4.      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_counter_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, dir = 1'b0, auto_rl = 1'b0;
  logic [2:0] limit = 3'd0;

  int         total = 0;
  int         bad = 0;
  logic [5:0] sbq[$];
  logic [5:0] exp_v;
  logic [5:0] obs;

  counter_sequencer_if #(.WIDTH(3)) if1 ();
  counter_sequencer_if #(.WIDTH(3)) if2 ();
  counter_sequencer_if #(.WIDTH(3)) if4 ();

  assign if1.start = start; assign if1.stop = stop; assign if1.clear = clear;
  assign if1.dir = dir; assign if1.auto_rl = auto_rl; assign if1.limit = limit;
  assign if2.start = start; assign if2.stop = stop; assign if2.clear = clear;
  assign if2.dir = dir; assign if2.auto_rl = auto_rl; assign if2.limit = limit;
  assign if4.start = start; assign if4.stop = stop; assign if4.clear = clear;
  assign if4.dir = dir; assign if4.auto_rl = auto_rl; assign if4.limit = limit;

  counter_sequencer #(.WIDTH(3), .DIV(1)) u1 (.clk(clk), .reset(reset), .ctl(if1));
  counter_sequencer #(.WIDTH(3), .DIV(2)) u2 (.clk(clk), .reset(reset), .ctl(if2));
  counter_sequencer #(.WIDTH(3), .DIV(4)) u4 (.clk(clk), .reset(reset), .ctl(if4));

  always #5 clk = ~clk;

  // Expected observation word {count, busy, done, wrap} from a binary count value.
  function automatic logic [5:0] ex(input int c, input logic b, input logic d, input logic w);
    logic [2:0] v;
    v = 3'(c);
`ifdef COUNTER_SEQUENCER_GRAY_EN
    v = v ^ (v >> 1);
`endif
    return {v, b, d, w};
  endfunction

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] o3 [3];
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    o3[0] = {if1.count, if1.busy, if1.done, if1.wrap};
    o3[1] = {if2.count, if2.busy, if2.done, if2.wrap};
    o3[2] = {if4.count, if4.busy, if4.done, if4.wrap};
    for (int i = 0; i < 3; i++) sbq.push_back(ex(0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      exp_v = sbq.pop_front();
      total++;
      if (o3[i] !== exp_v) begin
        bad++;
        $display("FAIL reset_assert inst=%0d got=%b want=%b", i, o3[i], exp_v);
      end
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    sbq.push_back(ex(0, 0, 0, 0));
    exp_v = sbq.pop_front();
    obs = {if4.count, if4.busy, if4.done, if4.wrap};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL reset_release got=%b want=%b", obs, exp_v);
    end
  endtask

  task automatic test_up_oneshot();
    pulse_clear();
    dir = 1'b0; auto_rl = 1'b0; limit = 3'd5; start = 1'b1;
    for (int v = 0; v <= 5; v++) repeat (2) sbq.push_back(ex(v, 1, 0, 0));
    sbq.push_back(ex(5, 0, 1, 0));
    sbq.push_back(ex(5, 0, 0, 0));
    while (sbq.size() > 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp_v = sbq.pop_front();
      obs = {if2.count, if2.busy, if2.done, if2.wrap};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL up_oneshot got=%b want=%b", obs, exp_v);
      end
    end
  endtask

  task automatic test_down_reload();
    pulse_clear();
    dir = 1'b1; auto_rl = 1'b1; limit = 3'd3; start = 1'b1;
    for (int rep = 0; rep < 2; rep++)
      for (int v = 3; v >= 0; v--)
        for (int k = 0; k < 2; k++)
          sbq.push_back(ex(v, 1, 0, (rep > 0 && v == 3 && k == 0)));
    sbq.push_back(ex(3, 1, 0, 1));
    sbq.push_back(ex(3, 1, 0, 0));
    while (sbq.size() > 0) begin
      @(posedge clk); #1;
      // input changes after the start must not disturb the latched settings
      start = 1'b0; dir = 1'b0; auto_rl = 1'b0; limit = 3'd7;
      exp_v = sbq.pop_front();
      obs = {if2.count, if2.busy, if2.done, if2.wrap};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL down_reload got=%b want=%b", obs, exp_v);
      end
    end
  endtask

  task automatic test_pause_resume();
    pulse_clear();
    dir = 1'b0; auto_rl = 1'b0; limit = 3'd7; start = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      if (c <= 4)       sbq.push_back(ex(0, 1, 0, 0));
      else if (c <= 8)  sbq.push_back(ex(1, 1, 0, 0));
      else if (c <= 10) sbq.push_back(ex(2, 1, 0, 0));
      else if (c <= 20) sbq.push_back(ex(2, 0, 0, 0));
      else if (c <= 23) sbq.push_back(ex(2, 1, 0, 0));
      else              sbq.push_back(ex(3, 1, 0, 0));
    end
    for (int c = 1; c <= 27; c++) begin
      @(posedge clk); #1;
      exp_v = sbq.pop_front();
      obs = {if4.count, if4.busy, if4.done, if4.wrap};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL pause_resume cyc=%0d got=%b want=%b", c, obs, exp_v);
      end
      case (c)
        1:  start = 1'b0;
        10: stop  = 1'b1;
        11: stop  = 1'b0;
        15: stop  = 1'b1;
        16: stop  = 1'b0;
        20: start = 1'b1;
        21: start = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_div1_edges();
    pulse_clear();
    dir = 1'b0; auto_rl = 1'b0; limit = 3'd0; start = 1'b1;
    sbq.push_back(ex(0, 1, 0, 0)); sbq.push_back(ex(0, 0, 1, 0)); sbq.push_back(ex(0, 0, 0, 0));
    sbq.push_back(ex(0, 1, 0, 0)); sbq.push_back(ex(0, 1, 0, 1)); sbq.push_back(ex(0, 1, 0, 1));
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      exp_v = sbq.pop_front();
      obs = {if1.count, if1.busy, if1.done, if1.wrap};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL div1_limit0 cyc=%0d got=%b want=%b", c, obs, exp_v);
      end
      case (c)
        1: start = 1'b0;
        3: begin start = 1'b1; dir = 1'b1; auto_rl = 1'b1; end
        4: start = 1'b0;
        default: ;
      endcase
    end
    pulse_clear();
    dir = 1'b0; auto_rl = 1'b1; limit = 3'd7; start = 1'b1;
    sbq.push_back(ex(0, 1, 0, 0)); sbq.push_back(ex(1, 1, 0, 0)); sbq.push_back(ex(1, 0, 0, 0));
    sbq.push_back(ex(1, 0, 0, 0)); sbq.push_back(ex(1, 1, 0, 0)); sbq.push_back(ex(2, 1, 0, 0));
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      exp_v = sbq.pop_front();
      obs = {if1.count, if1.busy, if1.done, if1.wrap};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL start_stop_same cyc=%0d got=%b want=%b", c, obs, exp_v);
      end
      case (c)
        1: start = 1'b0;
        2: begin start = 1'b1; stop = 1'b1; end
        3: begin start = 1'b0; stop = 1'b0; end
        4: start = 1'b1;
        5: start = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_clear_and_async_reset();
    pulse_clear();
    dir = 1'b0; auto_rl = 1'b0; limit = 3'd7; start = 1'b1;
    for (int v = 0; v <= 4; v++) sbq.push_back(ex(v, 1, 0, 0));
    sbq.push_back(ex(0, 0, 0, 0));
    sbq.push_back(ex(0, 0, 0, 0));
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      exp_v = sbq.pop_front();
      obs = {if1.count, if1.busy, if1.done, if1.wrap};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL clear_mid_run cyc=%0d got=%b want=%b", c, obs, exp_v);
      end
      if (c == 1) start = 1'b0;
      if (c == 5) clear = 1'b1;
      if (c == 6) clear = 1'b0;
    end
    start = 1'b1;
    for (int v = 0; v <= 4; v++) sbq.push_back(ex(v, 1, 0, 0));
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp_v = sbq.pop_front();
      obs = {if1.count, if1.busy, if1.done, if1.wrap};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL rerun_before_reset cyc=%0d got=%b want=%b", c, obs, exp_v);
      end
    end
    #2 reset = 1'b0;
    #1;
    sbq.push_back(ex(0, 0, 0, 0));
    exp_v = sbq.pop_front();
    obs = {if1.count, if1.busy, if1.done, if1.wrap};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL async_reset_mid_run got=%b want=%b", obs, exp_v);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    sbq.push_back(ex(0, 0, 0, 0));
    exp_v = sbq.pop_front();
    obs = {if1.count, if1.busy, if1.done, if1.wrap};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL after_async_reset got=%b want=%b", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    dir = 1'b0; auto_rl = 1'b0; limit = 3'd7; start = 1'b1;
    for (int v = 0; v <= 7; v++) sbq.push_back(ex(v, 1, 0, 0));
    sbq.push_back(ex(7, 0, 1, 0));
    sbq.push_back(ex(2, 1, 0, 0)); sbq.push_back(ex(1, 1, 0, 0)); sbq.push_back(ex(0, 1, 0, 0));
    sbq.push_back(ex(0, 0, 1, 0)); sbq.push_back(ex(0, 0, 0, 0));
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      exp_v = sbq.pop_front();
      obs = {if1.count, if1.busy, if1.done, if1.wrap};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL full_range_back_to_back cyc=%0d got=%b want=%b", c, obs, exp_v);
      end
      if (c == 1) start = 1'b0;
      if (c == 9) begin start = 1'b1; dir = 1'b1; limit = 3'd2; end
      if (c == 10) start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_up_oneshot();
    test_down_reload();
    test_pause_resume();
    test_div1_edges();
    test_clear_and_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
